periferico_bin_bcd_n: RTL and testbench

PERIFERICO_BIN_BCD_N -- requirements
Module: periferico_bin_bcd_n

---
 rtl/periferico_bin_bcd_n_if.sv | 31 +++
 rtl/periferico_bin_bcd_n.sv | 171 +++++++++++++++++
 tb/tb_periferico_bin_bcd_n.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/periferico_bin_bcd_n_if.sv
// Bus bundle for the binary-to-BCD peripheral: chip-select qualified
// read/write strobes, byte address, data in/out and the level interrupt.
interface periferico_bin_bcd_n_if;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [5:0]  addr;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        irq;

    modport master (
        output cs,
        output rd,
        output wr,
        output addr,
        output d_in,
        input  d_out,
        input  irq
    );

    modport slave (
        input  cs,
        input  rd,
        input  wr,
        input  addr,
        input  d_in,
        output d_out,
        output irq
    );
endinterface

// File: rtl/periferico_bin_bcd_n.sv
// Memory-mapped binary-to-BCD converter: a WIDTH-bit operand (optionally signed)
// is turned into five BCD digits by a sequential double-dabble, one bit per cycle.
module periferico_bin_bcd_n #(
    parameter int WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   reset,
    periferico_bin_bcd_n_if.slave  bus
);

    localparam logic [5:0] ADDR_OP_A   = 6'h04;
    localparam logic [5:0] ADDR_CTRL   = 6'h08;
    localparam logic [5:0] ADDR_BCD_LO = 6'h0C;
    localparam logic [5:0] ADDR_BCD_HI = 6'h10;
    localparam logic [5:0] ADDR_STATUS = 6'h14;
    localparam logic [4:0] CNT_LAST    = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [WIDTH-1:0]   op_a_reg;
    logic               signed_reg;
    logic               irq_en_reg;
    logic [WIDTH-1:0]   sr_reg;
    logic [19:0]        bcd_reg;
    logic [4:0]         cnt_reg;
    logic               neg_reg;
    logic               done_reg;
    logic [15:0]        bcd_lo_reg;
    logic [3:0]         bcd_dig4_reg;
    logic               bcd_sign_reg;
    logic [15:0]        d_out_reg;

    logic               wr_en;
    logic               rd_en;
    logic               busy;
    logic               start_req;
    logic               start_acc;
    logic               status_rd;
    logic               last_iter;
    logic               set_done;
    logic               op_neg;
    logic [WIDTH-1:0]   op_mag;
    logic [19:0]        bcd_adj;
    logic [20:0]        bcd_shift;
    logic [15:0]        rd_data;
    logic               unused_d_in;

    assign wr_en     = bus.cs & bus.wr;
    assign rd_en     = bus.cs & bus.rd;
    assign busy      = (state_reg == LOAD) || (state_reg == SHIFT);
    assign start_req = wr_en && (bus.addr == ADDR_CTRL) && bus.d_in[0];
    assign start_acc = start_req && !busy;
    assign status_rd = rd_en && (bus.addr == ADDR_STATUS);
    assign last_iter = (cnt_reg == CNT_LAST);
    assign set_done  = (state_reg == SHIFT) && last_iter;

    // Most negative value wraps to itself, which read unsigned is +2^(WIDTH-1).
    assign op_neg = signed_reg & op_a_reg[WIDTH-1];
    assign op_mag = op_neg ? ((~op_a_reg) + WIDTH'(1)) : op_a_reg;

    // Double-dabble correction: every digit of 5 or more gets +3 before the shift.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_digit_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                        ? (bcd_reg[gi*4 +: 4] + 4'd3)
                                        : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign bcd_shift = {bcd_adj, sr_reg[WIDTH-1]};

    assign unused_d_in = ^bus.d_in;

    always_comb begin
        rd_data = 16'h0000;
        case (bus.addr)
            ADDR_OP_A:   rd_data = 16'(op_a_reg);
            ADDR_CTRL:   rd_data = {13'd0, irq_en_reg, signed_reg, 1'b0};
            ADDR_BCD_LO: rd_data = bcd_lo_reg;
            ADDR_BCD_HI: rd_data = {bcd_sign_reg, 11'd0, bcd_dig4_reg};
            ADDR_STATUS: rd_data = {13'd0, neg_reg, busy, done_reg};
            default:     rd_data = 16'h0000;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_req) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (last_iter) state_next = DONE;
            DONE:    if (start_req) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            op_a_reg     <= '0;
            signed_reg   <= 1'b0;
            irq_en_reg   <= 1'b0;
            sr_reg       <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            neg_reg      <= 1'b0;
            done_reg     <= 1'b0;
            bcd_lo_reg   <= '0;
            bcd_dig4_reg <= '0;
            bcd_sign_reg <= 1'b0;
            d_out_reg    <= '0;
        end else begin
            if (wr_en && (bus.addr == ADDR_OP_A)) begin
                op_a_reg <= bus.d_in[WIDTH-1:0];
            end
            if (wr_en && (bus.addr == ADDR_CTRL)) begin
                signed_reg <= bus.d_in[1];
                irq_en_reg <= bus.d_in[2];
            end
            // rd_data reflects pre-edge registers, so a same-cycle write is not seen.
            if (rd_en) begin
                d_out_reg <= rd_data;
            end

            case (state_reg)
                LOAD: begin
                    sr_reg  <= op_mag;
                    bcd_reg <= '0;
                    cnt_reg <= '0;
                    neg_reg <= op_neg;
                end
                SHIFT: begin
                    bcd_reg <= bcd_shift[19:0];
                    sr_reg  <= {sr_reg[WIDTH-2:0], 1'b0};
                    cnt_reg <= cnt_reg + 5'd1;
                    if (last_iter) begin
                        bcd_lo_reg   <= bcd_shift[15:0];
                        bcd_dig4_reg <= bcd_shift[19:16];
                        bcd_sign_reg <= neg_reg;
                    end
                end
                default: ;
            endcase

            if (set_done) begin
                done_reg <= 1'b1;
            end else if (start_acc || status_rd) begin
                done_reg <= 1'b0;
            end
        end
    end

    assign bus.d_out = d_out_reg;
    assign bus.irq   = done_reg & irq_en_reg;

endmodule

// File: tb/tb_periferico_bin_bcd_n.sv
// Directed bench for the binary-to-BCD peripheral: a 16-bit and an 8-bit
// instance share one stimulus bus, selected by sel.
module tb_periferico_bin_bcd_n;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        cs = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [5:0]  addr = 6'd0;
    logic [15:0] d_in = 16'd0;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [5:0] A_OP   = 6'h04;
    localparam logic [5:0] A_CTRL = 6'h08;
    localparam logic [5:0] A_LO   = 6'h0C;
    localparam logic [5:0] A_HI   = 6'h10;
    localparam logic [5:0] A_STAT = 6'h14;

    periferico_bin_bcd_n_if b16 ();
    periferico_bin_bcd_n_if b8 ();

    assign b16.cs   = cs & ~sel;
    assign b16.rd   = rd;
    assign b16.wr   = wr;
    assign b16.addr = addr;
    assign b16.d_in = d_in;
    assign b8.cs    = cs & sel;
    assign b8.rd    = rd;
    assign b8.wr    = wr;
    assign b8.addr  = addr;
    assign b8.d_in  = d_in;

    periferico_bin_bcd_n #(.WIDTH(16)) dut16 (.CLK(CLK), .reset(reset), .bus(b16));
    periferico_bin_bcd_n #(.WIDTH(8))  dut8  (.CLK(CLK), .reset(reset), .bus(b8));

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr_reg(input logic s, input logic [5:0] a, input logic [15:0] d);
        @(negedge CLK);
        sel = s; cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
        @(posedge CLK);
        #1;
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic rd_check(input logic s, input logic [5:0] a, input logic [15:0] exp, input string tag);
        @(negedge CLK);
        sel = s; cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        @(posedge CLK);
        #1;
        cs = 1'b0; rd = 1'b0;
        check(tag, s ? b8.d_out : b16.d_out, exp);
    endtask

    task automatic rdwr_check(input logic s, input logic [5:0] a, input logic [15:0] d, input logic [15:0] exp, input string tag);
        @(negedge CLK);
        sel = s; cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(posedge CLK);
        #1;
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        check(tag, s ? b8.d_out : b16.d_out, exp);
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge CLK);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #2;
        check("rst_dout16", b16.d_out, 16'h0000);
        check("rst_irq16", 16'(b16.irq), 16'h0000);
        @(negedge CLK);
        reset = 1'b0;
        check("rst_dout8", b8.d_out, 16'h0000);
        rd_check(0, A_STAT, 16'h0000, "rst_status");
        rd_check(0, A_OP, 16'h0000, "rst_op_a");

        // Simultaneous read+write returns the pre-write value
        wr_reg(0, A_OP, 16'h1111);
        rdwr_check(0, A_OP, 16'h04D2, 16'h1111, "rdwr_old");
        rd_check(0, A_OP, 16'h04D2, "rdwr_new");
        rd_check(0, 6'h00, 16'h0000, "unmapped_00");
        rd_check(0, 6'h18, 16'h0000, "unmapped_18");

        // 1234 unsigned, exact DONE latency
        wr_reg(0, A_CTRL, 16'h0001);
        wait_edges(16);
        rd_check(0, A_STAT, 16'h0002, "lat_busy_k17");
        rd_check(0, A_STAT, 16'h0001, "lat_done_k18");
        rd_check(0, A_STAT, 16'h0000, "done_cleared");
        rd_check(0, A_LO, 16'h1234, "1234_lo");
        rd_check(0, A_HI, 16'h0000, "1234_hi");

        // 65535 unsigned
        wr_reg(0, A_OP, 16'hFFFF);
        wr_reg(0, A_CTRL, 16'h0001);
        wait_edges(20);
        rd_check(0, A_LO, 16'h5535, "65535_lo");
        rd_check(0, A_HI, 16'h0006, "65535_hi");
        rd_check(0, A_STAT, 16'h0001, "65535_status");

        // Signed -1234
        wr_reg(0, A_OP, 16'hFB2E);
        wr_reg(0, A_CTRL, 16'h0003);
        wait_edges(20);
        rd_check(0, A_LO, 16'h1234, "neg1234_lo");
        rd_check(0, A_HI, 16'h8000, "neg1234_hi");
        rd_check(0, A_STAT, 16'h0005, "neg1234_status");
        rd_check(0, A_CTRL, 16'h0002, "ctrl_readback");

        // Signed most-negative value
        wr_reg(0, A_OP, 16'h8000);
        wr_reg(0, A_CTRL, 16'h0003);
        wait_edges(20);
        rd_check(0, A_LO, 16'h2768, "min_lo");
        rd_check(0, A_HI, 16'h8003, "min_hi");

        // START and OP_A write during BUSY, result hold, irq and STATUS clear
        wr_reg(0, A_OP, 16'h0064);
        wr_reg(0, A_CTRL, 16'h0005);
        rd_check(0, A_LO, 16'h2768, "hold_during_busy");
        wr_reg(0, A_OP, 16'h00C8);
        wr_reg(0, A_CTRL, 16'h0005);
        rd_check(0, A_STAT, 16'h0002, "busy_status");
        wait_edges(20);
        check("irq_high", 16'(b16.irq), 16'h0001);
        rd_check(0, A_LO, 16'h0100, "ignored_start_lo");
        rd_check(0, A_OP, 16'h00C8, "op_a_updated");
        rd_check(0, A_STAT, 16'h0001, "status_done");
        check("irq_low", 16'(b16.irq), 16'h0000);
        rd_check(0, A_STAT, 16'h0000, "status_after_clear");

        // Reset mid-conversion
        wr_reg(0, A_OP, 16'h10E1);
        wr_reg(0, A_CTRL, 16'h0001);
        rd_check(0, A_LO, 16'h0100, "pre_reset_dout");
        wait_edges(8);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_dout", b16.d_out, 16'h0000);
        check("midrst_irq", 16'(b16.irq), 16'h0000);
        @(negedge CLK);
        reset = 1'b0;
        rd_check(0, A_STAT, 16'h0000, "postrst_status");
        rd_check(0, A_OP, 16'h0000, "postrst_op_a");
        rd_check(0, A_LO, 16'h0000, "postrst_lo");
        rd_check(0, A_CTRL, 16'h0000, "postrst_ctrl");
        wr_reg(0, A_OP, 16'h10E1);
        wr_reg(0, A_CTRL, 16'h0001);
        wait_edges(20);
        rd_check(0, A_LO, 16'h4321, "postrst_conv_lo");
        rd_check(0, A_STAT, 16'h0001, "postrst_conv_status");

        // WIDTH=8 instance
        wr_reg(1, A_OP, 16'h00FF);
        wr_reg(1, A_CTRL, 16'h0001);
        wait_edges(8);
        rd_check(1, A_STAT, 16'h0002, "w8_busy_k9");
        rd_check(1, A_STAT, 16'h0001, "w8_done_k10");
        rd_check(1, A_LO, 16'h0255, "w8_255_lo");
        rd_check(1, A_HI, 16'h0000, "w8_255_hi");
        wr_reg(1, A_OP, 16'h01FF);
        rd_check(1, A_OP, 16'h00FF, "w8_op_mask");
        wr_reg(1, A_OP, 16'h0080);
        wr_reg(1, A_CTRL, 16'h0003);
        wait_edges(12);
        rd_check(1, A_LO, 16'h0128, "w8_min_lo");
        rd_check(1, A_HI, 16'h8000, "w8_min_hi");
        rd_check(1, A_STAT, 16'h0005, "w8_min_status");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
